// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

  // Data-memory wait tracking states
  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_FAULT
  } dstate_t;

  // Wrong-path fetch discard tracking states
  typedef enum logic {
    F_IDLE,
    F_DISCARD
  } fstate_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  // Increment on request, holding at all-ones instead of wrapping
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect,
// instruction-fetch wait/discard and data-memory wait/timeout handling.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 256,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             imem_ready,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             pc_redirect_en,
  output logic             drop_fetch,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  // Wait counter only needs to reach DMEM_TIMEOUT; it saturates beyond that
  localparam int WCNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TMO_LIMIT = WCNT_W'(DMEM_TIMEOUT);
  localparam logic              TMO_EN    = (DMEM_TIMEOUT != 0);

  dstate_t           dstate_d, dstate_q;
  fstate_t           fstate_d, fstate_q;
  logic [WCNT_W-1:0] wcnt_d, wcnt_q, wcnt_inc;
  logic              mem_timeout_d, mem_timeout_q;
  logic              mem_stall, load_use, redirect, fetch_stall;

  assign mem_stall   = (dmem_req_mem & ~dmem_ready) | (dstate_q == D_FAULT);
  assign load_use    = mem_read_ex & (rd_ex != REG_X0) &
                       ((rs1_used_id & (rs1_id == rd_ex)) |
                        (rs2_used_id & (rs2_id == rd_ex)));
  assign redirect    = branch_taken_ex & ~mem_stall;
  assign fetch_stall = ~imem_ready | (fstate_q == F_DISCARD);
  assign wcnt_inc    = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);

  // Prioritised stall/flush decode; everything is held low during reset
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_wb       = 1'b0;
    pc_redirect_en = 1'b0;
    drop_fetch     = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        // Freeze IF..MEM and bubble WB; a pending redirect waits
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else begin
        drop_fetch = (fstate_q == F_DISCARD) & imem_ready;
        if (redirect) begin
          // ID holds a wrong-path instruction, so redirect wins over load-use
          pc_redirect_en = 1'b1;
          flush_id       = 1'b1;
          flush_ex       = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end else if (fetch_stall) begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
      end
    end
  end

  // Data-memory wait tracking with saturating wait count and sticky timeout
  always_comb begin
    dstate_d      = dstate_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    case (dstate_q)
      D_IDLE: begin
        if (dmem_req_mem && !dmem_ready) begin
          wcnt_d = WCNT_W'(1);
          if (TMO_EN && (WCNT_W'(1) >= TMO_LIMIT)) begin
            dstate_d      = D_FAULT;
            mem_timeout_d = 1'b1;
          end else begin
            dstate_d = D_WAIT;
          end
        end
      end
      D_WAIT: begin
        if (dmem_ready) begin
          dstate_d = D_IDLE;
        end else begin
          wcnt_d = wcnt_inc;
          if (TMO_EN && (wcnt_inc >= TMO_LIMIT)) begin
            dstate_d      = D_FAULT;
            mem_timeout_d = 1'b1;
          end
        end
      end
      D_FAULT: dstate_d = D_FAULT;
      default: dstate_d = D_IDLE;
    endcase
  end

  // Wrong-path fetch discard: one outstanding beat to throw away after a redirect
  always_comb begin
    fstate_d = fstate_q;
    case (fstate_q)
      F_IDLE:    if (pc_redirect_en && !imem_ready) fstate_d = F_DISCARD;
      F_DISCARD: if (imem_ready) fstate_d = F_IDLE;
      default:   fstate_d = F_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate_q      <= D_IDLE;
      fstate_q      <= F_IDLE;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      dstate_q      <= dstate_d;
      fstate_q      <= fstate_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  hazard_sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .q     (cnt_stall)
  );

  hazard_sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect_en),
    .q     (cnt_flush)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit (DMEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_control_unit;

  localparam int CW = 4;

  // Control vector order: {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,flush_wb,pc_redirect_en,drop_fetch}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] MEMST = 9'b111100100;
  localparam logic [8:0] REDIR = 9'b000011010;
  localparam logic [8:0] LU    = 9'b110001000;
  localparam logic [8:0] FST   = 9'b100010000;
  localparam logic [8:0] FDROP = 9'b100010001;

  logic          clk, rst_n;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex;
  logic          imem_ready, dmem_req_mem, dmem_ready;
  logic          stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, flush_ex, flush_wb, pc_redirect_en, drop_fetch, mem_timeout;
  logic [CW-1:0] cnt_stall, cnt_flush;
  logic [8:0]    ctrl_v;

  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_control_unit #(.DMEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .branch_taken_ex (branch_taken_ex),
    .imem_ready      (imem_ready),
    .dmem_req_mem    (dmem_req_mem),
    .dmem_ready      (dmem_ready),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .flush_wb        (flush_wb),
    .pc_redirect_en  (pc_redirect_en),
    .drop_fetch      (drop_fetch),
    .mem_timeout     (mem_timeout),
    .cnt_stall       (cnt_stall),
    .cnt_flush       (cnt_flush)
  );

  assign ctrl_v = {stall_if, stall_id, stall_ex, stall_mem, flush_id,
                   flush_ex, flush_wb, pc_redirect_en, drop_fetch};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; imem_ready = 1'b1;
    dmem_req_mem = 1'b0; dmem_ready = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the counter model on the edge
  task automatic step(input string tag, input logic [8:0] exp_v);
    @(negedge clk);
    check_eq({tag, "/ctl"}, 32'(ctrl_v), 32'(exp_v));
    check_eq({tag, "/cnt_stall"}, 32'(cnt_stall), 32'(exp_stall));
    check_eq({tag, "/cnt_flush"}, 32'(cnt_flush), 32'(exp_flush));
    @(posedge clk);
    if (exp_v[8] && exp_stall != 15) exp_stall++;
    if (exp_v[1] && exp_flush != 15) exp_flush++;
    #1;
  endtask

  // Asserts reset with whatever hazards are on the inputs, checks everything is cleared
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst/ctl", 32'(ctrl_v), 32'(NONE));
    check_eq("rst/cnt_stall", 32'(cnt_stall), 32'd0);
    check_eq("rst/cnt_flush", 32'(cnt_flush), 32'd0);
    check_eq("rst/mem_timeout", 32'(mem_timeout), 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_in();
    #2;
    // Reset with a data-memory stall and fetch stall pending on the inputs
    dmem_req_mem = 1'b1; imem_ready = 1'b0; branch_taken_ex = 1'b1;
    do_reset();
    step("idle", NONE);

    // Load-use through rs2, then consumer proceeds
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    step("lu_rs2", LU);
    mem_read_ex = 1'b0;
    step("lu_after", NONE);
    // Load-use through rs1, and the same match with rs1 not read
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs1_used_id = 1'b1;
    rs2_id = 5'd3;
    step("lu_rs1", LU);
    rs1_used_id = 1'b0;
    step("lu_unused", NONE);
    // x0 destination never stalls
    rd_ex = 5'd0; rs2_id = 5'd0; rs2_used_id = 1'b1;
    step("lu_x0", NONE);
    idle_in();

    // Redirect beats load-use
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    branch_taken_ex = 1'b1;
    step("redir_lu", REDIR);
    idle_in();
    step("redir_after", NONE);
    check_eq("redir/cnt_flush", 32'(cnt_flush), 32'd1);

    // Three data-memory wait cycles with a branch deferred behind them
    dmem_req_mem = 1'b1; dmem_ready = 1'b0; branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) step("dmem_wait", MEMST);
    dmem_ready = 1'b1;
    step("dmem_done_redir", REDIR);
    idle_in();
    step("dmem_idle", NONE);
    check_eq("dmem/mem_timeout", 32'(mem_timeout), 32'd0);

    // Plain fetch stall
    imem_ready = 1'b0;
    step("fetch_stall", FST);
    imem_ready = 1'b1;
    step("fetch_ok", NONE);

    // Redirect with a fetch outstanding: the late beat is dropped
    branch_taken_ex = 1'b1; imem_ready = 1'b0;
    step("fd_redir", REDIR);
    branch_taken_ex = 1'b0;
    step("fd_wait", FST);
    imem_ready = 1'b1;
    step("fd_drop", FDROP);
    step("fd_idle", NONE);

    // Timeout after four wait cycles, then held until reset
    dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step("tmo_wait", MEMST);
      check_eq("tmo_flag", 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
    end
    dmem_req_mem = 1'b0; dmem_ready = 1'b1; branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) step("tmo_hold", MEMST);
    check_eq("tmo_sticky", 32'(mem_timeout), 32'd1);
    do_reset();
    step("tmo_cleared", NONE);
    check_eq("tmo_after_rst", 32'(mem_timeout), 32'd0);

    // Counter saturation under a long fetch stall
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step("sat", FST);
    check_eq("sat/cnt_stall", 32'(cnt_stall), 32'd15);
    imem_ready = 1'b1;
    step("sat_end", NONE);
    check_eq("sat/hold", 32'(cnt_stall), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
